// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store
// stage and datamem; two-block line refill, dirty-victim writeback, full flush.
module dcache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int BLOCK_SIZE = 512,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [WORD_SIZE-1:0]  cpu_addr,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  input  logic                  cpu_flush,
  output logic                  cpu_ready,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata1,
  input  logic [BLOCK_SIZE-1:0] mem_rdata2,
  output logic                  mem_flush,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int LINE_W     = 2 * BLOCK_SIZE;
  localparam int WORDS      = LINE_W / WORD_SIZE;
  localparam int OFF_W      = $clog2(LINE_W / BYTE_SIZE);
  localparam int IDX_W      = $clog2(LINES);
  localparam int TAG_W      = WORD_SIZE - OFF_W - IDX_W;
  localparam int BOFF_W     = $clog2(WORD_SIZE / BYTE_SIZE);
  localparam int WSEL_W     = OFF_W - BOFF_W;
  localparam int HALF_BYTES = BLOCK_SIZE / BYTE_SIZE;

  typedef enum logic [2:0] {
    IDLE, WB_LO, WB_GAP, WB_HI, FILL, FILL_DATA, FLUSH_SCAN, FLUSH_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [WORD_SIZE-1:0] data_q [LINES][WORDS];
  logic                 flushing_q;
  logic [IDX_W-1:0]     scan_idx_q;

  logic [IDX_W-1:0]     req_idx, wb_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [WSEL_W-1:0]    req_word;
  logic                 hit, scan_last, idle_access;
  logic [WORD_SIZE-1:0] wb_base, fill_base;
  logic [LINE_W-1:0]    wb_line, fill_line;

  // Byte-offset bits inside a word never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[BOFF_W-1:0];

  assign req_idx   = cpu_addr[OFF_W +: IDX_W];
  assign req_tag   = cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign req_word  = cpu_addr[BOFF_W +: WSEL_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cpu_rdata = data_q[req_idx][req_word];

  assign idle_access = (state_q == IDLE) && cpu_req && !cpu_flush;
  assign cpu_ready   = idle_access && hit;

  // The writeback path serves both a miss victim and the flush walker.
  assign wb_idx    = flushing_q ? scan_idx_q : req_idx;
  assign wb_base   = {tag_q[wb_idx], wb_idx, {OFF_W{1'b0}}};
  assign fill_base = {cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
  assign scan_last = (scan_idx_q == IDX_W'(LINES - 1));
  assign fill_line = {mem_rdata1, mem_rdata2};

  // Word 0 sits at the top of the low half: big-endian byte order in a block.
  always_comb begin
    wb_line = '0;
    for (int w = 0; w < WORDS; w++)
      wb_line[LINE_W-1-WORD_SIZE*w -: WORD_SIZE] = data_q[wb_idx][w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process evaluation order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case statement leaves a value unassigned and infers a latch.
    state_d   = state_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_flush)
          state_d = FLUSH_SCAN;
        else if (cpu_req && !hit)
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB_LO : FILL;
      end
      WB_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = wb_base;
        mem_wdata = wb_line[LINE_W-1 -: BLOCK_SIZE];
        state_d   = WB_GAP;
      end
      WB_GAP: state_d = WB_HI;
      WB_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = wb_base + WORD_SIZE'(HALF_BYTES);
        mem_wdata = wb_line[BLOCK_SIZE-1:0];
        if (!flushing_q)    state_d = FILL;
        else if (scan_last) state_d = FLUSH_DONE;
        else                state_d = FLUSH_SCAN;
      end
      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = fill_base;
        state_d  = FILL_DATA;
      end
      FILL_DATA: begin
        mem_addr = fill_base;
        state_d  = IDLE;
      end
      FLUSH_SCAN: begin
        if (dirty_q[scan_idx_q]) state_d = WB_LO;
        else if (scan_last)      state_d = FLUSH_DONE;
      end
      FLUSH_DONE: mem_flush = 1'b1;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      flushing_q <= 1'b0;
      scan_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          scan_idx_q <= '0;
          if (cpu_flush) flushing_q <= 1'b1;
          if (cpu_ready && cpu_we) dirty_q[req_idx] <= 1'b1;
        end
        FILL_DATA: begin
          valid_q[req_idx] <= 1'b1;
          dirty_q[req_idx] <= 1'b0;
        end
        WB_HI: begin
          if (flushing_q) begin
            dirty_q[scan_idx_q] <= 1'b0;
            if (!scan_last) scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        FLUSH_SCAN: begin
          if (!dirty_q[scan_idx_q] && !scan_last) scan_idx_q <= scan_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits gate
  // every use of them, and leaving them reset-free lets them map to plain RAM.
  always_ff @(posedge clk) begin
    if (cpu_ready && cpu_we)
      data_q[req_idx][req_word] <= cpu_wdata;
    if (state_q == FILL_DATA) begin
      tag_q[req_idx] <= req_tag;
      for (int w = 0; w < WORDS; w++)
        data_q[req_idx][w] <= fill_line[LINE_W-1-WORD_SIZE*w -: WORD_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (cpu_ready && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (idle_access && !hit && miss_count != '1)
        miss_count <= miss_count + 1'b1;
    end
  end

endmodule
